// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and iteration count for hilo_muldiv_unit.
package muldiv_pkg;
    localparam int MULDIV_ITERS = 32;
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: issue/result bundle between the pipeline and the HI/LO unit.
interface hilo_muldiv_unit_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITERS
);
    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, operand_a, operand_b, input busy, done, hi, lo);
    modport slave (input start, op, operand_a, operand_b, output busy, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv_unit_divider.sv
// iter_divider: unsigned restoring divider, one quotient bit per enabled cycle after load.
module iter_divider
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITERS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q;
    logic [WIDTH:0]   shifted, diff;
    // diff[WIDTH] set means the trial subtraction went negative: restore
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        rem_d   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    end
    always_ff @(posedge clk)
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (clk_enable) begin
            quo_q <= load ? dividend : quo_d;
            rem_q <= load ? '0 : rem_d;
            dvs_q <= load ? divisor : dvs_q;
        end
    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO, owning HI/LO.
// Define FAST_MULT_EN for a single-cycle multiplier; divide stays iterative.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITERS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    hilo_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d, prod_res;
    logic [WIDTH-1:0]     mcand_q, hi_q, lo_q, mag_a, mag_b, quo, rem, quo_res, rem_res;
    logic [WIDTH:0]       sum;
    logic                 is_div_q, neg_q, aneg_q, dz_q, done_q;
    logic                 accept, is_signed, is_mul, is_div, launch, busy;
    always_comb begin
        accept    = clk_enable && bus.start && !busy;
        is_mul    = bus.op == OP_MULT || bus.op == OP_MULTU;
        is_div    = bus.op == OP_DIV || bus.op == OP_DIVU;
        is_signed = bus.op == OP_MULT || bus.op == OP_DIV;
        mag_a     = is_signed && bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
        mag_b     = is_signed && bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;
        sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q & {WIDTH{prod_q[0]}}};
        prod_d    = {sum, prod_q[WIDTH-1:1]};
        prod_res  = neg_q ? -prod_q : prod_q;
        quo_res   = dz_q ? '1 : neg_q ? -quo : quo;
        rem_res   = aneg_q ? -rem : rem;
    end
`ifdef FAST_MULT_EN
    logic                      fast_q, fast_go;
    logic signed [2*WIDTH-1:0] sprod;
    logic [2*WIDTH-1:0]        uprod;
    assign fast_go = accept && is_mul;
    assign launch  = accept && is_div;
    assign sprod   = $signed(bus.operand_a) * $signed(bus.operand_b);
    assign uprod   = {{WIDTH{1'b0}}, bus.operand_a} * {{WIDTH{1'b0}}, bus.operand_b};
    always_ff @(posedge clk)
        if (reset) fast_q <= 1'b0;
        else if (clk_enable) fast_q <= fast_go;
`else
    assign launch = accept && (is_mul || is_div);
`endif
    always_ff @(posedge clk)
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (clk_enable) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    always_comb begin
        state_d = state_q == IDLE ? (launch ? RUN : IDLE)
                : state_q == RUN  ? (cnt_q == CW'(WIDTH - 1) ? FIN : RUN)
                : IDLE;
        cnt_d   = state_q == RUN ? cnt_q + 1'b1 : '0;
    end
    always_comb busy = state_q != IDLE;
    // Magnitudes iterate; signs are re-applied when HI/LO are written in FIN
    always_ff @(posedge clk)
        if (reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            aneg_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else if (clk_enable) begin
            done_q <= state_q == FIN;
            if (launch) begin
                prod_q   <= {{WIDTH{1'b0}}, mag_b};
                mcand_q  <= mag_a;
                is_div_q <= is_div;
                neg_q    <= is_signed && (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
                aneg_q   <= is_signed && bus.operand_a[WIDTH-1];
                dz_q     <= bus.operand_b == '0;
            end else if (state_q == RUN) begin
                prod_q <= prod_d;
            end
            if (state_q == FIN) {hi_q, lo_q} <= is_div_q ? {rem_res, quo_res} : prod_res;
`ifdef FAST_MULT_EN
            if (fast_go) prod_q <= is_signed ? sprod : uprod;
            if (fast_q) {hi_q, lo_q} <= prod_q;
            if (fast_q) done_q <= 1'b1;
`endif
            if (accept && bus.op == OP_MTHI) hi_q <= bus.operand_a;
            if (accept && bus.op == OP_MTLO) lo_q <= bus.operand_a;
        end
    iter_divider #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable && (launch || state_q == RUN)),
        .load       (launch),
        .dividend   (mag_a),
        .divisor    (mag_b),
        .quotient   (quo),
        .remainder  (rem)
    );
    assign bus.busy = busy;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed and randomized checks of hilo_muldiv_unit against a behavioural HI/LO model.
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;
`ifdef FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int L_ITER = 33;
    localparam int L_MUL  = FAST ? 1 : L_ITER;
    logic clk = 1'b0, reset = 1'b1, clk_enable = 1'b1;
    hilo_muldiv_unit_if bus ();
    hilo_muldiv_unit dut (.clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(bus));
    always #5 clk = ~clk;
    int errors = 0, checks = 0, lat;
    bit chk_en = 1'b0, seen;
    int m_left = 0;
    bit m_fast = 1'b0, m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res = '0, m_fres = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {hi, lo} an op must leave behind, from plain integer arithmetic
    function automatic logic [63:0] ref_result(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return {32'h0, a} * {32'h0, b};
            OP_DIV:   return b == 0 ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            OP_DIVU:  return b == 0 ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default:  return 64'h0;
        endcase
    endfunction

    always @(posedge clk)
        if (reset) begin
            m_hi = '0; m_lo = '0; m_done = 1'b0; m_left = 0; m_fast = 1'b0;
        end else if (clk_enable) begin
            m_done = 1'b0;
            if (m_fast) begin
                {m_hi, m_lo} = m_fres; m_done = 1'b1; m_fast = 1'b0;
            end
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    {m_hi, m_lo} = m_res; m_done = 1'b1;
                end
            end else if (bus.start) begin
                if (bus.op == OP_MTHI) m_hi = bus.operand_a;
                else if (bus.op == OP_MTLO) m_lo = bus.operand_a;
                else if (FAST && (bus.op == OP_MULT || bus.op == OP_MULTU)) begin
                    m_fast = 1'b1; m_fres = ref_result(bus.op, bus.operand_a, bus.operand_b);
                end else if (bus.op <= OP_DIVU) begin
                    m_left = L_ITER; m_res = ref_result(bus.op, bus.operand_a, bus.operand_b);
                end
            end
        end

    always @(negedge clk)
        if (chk_en) begin
            check("busy", 32'(bus.busy), 32'(m_left > 0));
            check("done", 32'(bus.done), 32'(m_done));
            check("hi", bus.hi, m_hi);
            check("lo", bus.lo, m_lo);
        end

    task automatic run_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                          input int st_at, input int st_len, input int poke, output int n);
        bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            clk_enable = !(i >= st_at && i < st_at + st_len);
            bus.start = (i == poke);
            bus.op = OP_MTHI; bus.operand_a = 32'hDEAD_BEEF;
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) begin
                n = i;
                break;
            end
        end
        clk_enable = 1'b1;
        if (n == 0) begin
            checks++; errors++;
            $display("FAIL run_op_timeout: got no done, expected done, op=%0d", o);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            4: return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.start = 1'b0; bus.op = OP_MULT; bus.operand_a = '0; bus.operand_b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; chk_en = 1'b1;
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, lat);
        check("t1_lat", lat, L_MUL);
        check("t1_hi", bus.hi, 32'hFFFF_FFFE);
        check("t1_lo", bus.lo, 32'h0000_0001);
        check("t1_model_hi", m_hi, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        check("t1_pulse", 32'(bus.done), 32'h0);
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0, 0, lat);
        check("t2_mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("t2_mult_lo", bus.lo, 32'hFFFF_FFEB);
        check("t2_model_lo", m_lo, 32'hFFFF_FFEB);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, lat);
        check("t2_div_lat", lat, L_ITER);
        check("t2_div_lo", bus.lo, 32'hFFFF_FFFD);
        check("t2_div_hi", bus.hi, 32'hFFFF_FFFF);
        run_op(OP_DIVU, 32'd100, 32'd0, 0, 0, 0, lat);
        check("t3_dz_lat", lat, L_ITER);
        check("t3_dz_lo", bus.lo, 32'hFFFF_FFFF);
        check("t3_dz_hi", bus.hi, 32'd100);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, lat);
        check("t3_ovf_lo", bus.lo, 32'h8000_0000);
        check("t3_ovf_hi", bus.hi, 32'h0);
        check("t3_model_lo", m_lo, 32'h8000_0000);
        bus.start = 1'b1; bus.op = OP_MTHI; bus.operand_a = 32'h1234;
        @(posedge clk); #1;
        check("t4_busy_a", 32'(bus.busy), 32'h0);
        bus.op = OP_MTLO; bus.operand_a = 32'h5678;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("t4_busy_b", 32'(bus.busy), 32'h0);
        check("t4_hi", bus.hi, 32'h1234);
        check("t4_lo", bus.lo, 32'h5678);
        check("t4_done", 32'(bus.done), 32'h0);
        run_op(OP_DIVU, 32'd50, 32'd7, 10, 5, 3, lat);
        check("t5_lat", lat, 38);
        check("t5_lo", bus.lo, 32'd7);
        check("t5_hi", bus.hi, 32'd1);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.operand_a = 32'h0001_0003; bus.operand_b = 32'h0002_0005;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1; clk_enable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; clk_enable = 1'b1;
        check("t6_hi", bus.hi, 32'h0);
        check("t6_lo", bus.lo, 32'h0);
        check("t6_busy", 32'(bus.busy), 32'h0);
        check("t6_done", 32'(bus.done), 32'h0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= bus.done;
        end
        check("t6_no_done", 32'(seen), 32'h0);
        run_op(OP_MULTU, 32'd6, 32'd7, 0, 0, 0, lat);
        check("t7_lat", lat, L_MUL);
        check("t7_lo", bus.lo, 32'd42);
        check("t7_hi", bus.hi, 32'h0);
        for (int c = 0; c < 3000; c++) begin
            reset = $urandom_range(0, 599) == 0;
            clk_enable = $urandom_range(0, 9) != 0;
            bus.start = $urandom_range(0, 2) == 0;
            bus.op = muldiv_op_t'(3'($urandom_range(0, 7)));
            bus.operand_a = pick();
            bus.operand_b = pick();
            @(posedge clk); #1;
        end
        reset = 1'b0; clk_enable = 1'b1; bus.start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
